multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle RV32I control unit: Moore FSM plus ALU decoder. Sequences fetch, decode, execute, memory and writeback over several cycles on a shared datapath with a single memory port.
- Successor to the single-cycle ctrl. Adds a memory wait handshake, optional bne support, illegal-opcode detection and parametrised control widths.
- Sits between the instruction register and the multicycle datapath muxes, register file and memory.

Parameters:
- ALU_CTRL_W, 3, width of alu_control.
- IMM_SRC_W, 2, width of imm_src.
- MEM_WAIT, 1, 1 = honour mem_ready; 0 = mem_ready internally tied to 1.
- EN_BNE, 1, 1 = decode funct3=001 branch as bne; 0 = that encoding is illegal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- op  in  7  opcode from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC load strobe.
- adr_src  out  1  0 = PC, 1 = ALUOut address.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction register load strobe.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rd1.
- alu_src_b  out  2  00 = rd2, 01 = imm, 10 = constant 4.
- imm_src  out  IMM_SRC_W  00 = I, 01 = S, 10 = B, 11 = J.
- alu_control  out  ALU_CTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky unsupported-opcode flag.

Behaviour:
- **Outputs:** Moore outputs decoded from state only, except the branch pc_write and the mem_ready-qualified strobes. Unlisted outputs are 0.
- **imm_src:** decoded from op in every state: lw/I-type 00, sw 01, branch 10, jal 11, else 00.
- **Reset:** when rst_n=0 at a clock edge, state <= FETCH and illegal <= 0. While rst_n=0, pc_write, ir_write, mem_write and reg_write are forced to 0 combinationally. Reset mid-instruction abandons it with no partial writeback.
- **FETCH:** adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- **DECODE:** alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - any other op -> FETCH with illegal <= 1
- **MEMADR:** alu_src_a=10, alu_src_b=01, add. lw -> MEMREAD, sw -> MEMWR.
- **MEMREAD:** adr_src=1, result_src=00. Stay until mem_ready, then MEMWB.
- **MEMWB:** result_src=01, reg_write=1 -> FETCH.
- **MEMWR:** adr_src=1, result_src=00. mem_write=1 held every cycle until mem_ready, then FETCH.
- **EXECR:** alu_src_a=10, alu_src_b=00, ALU decode -> ALUWB.
- **EXECI:** alu_src_a=10, alu_src_b=01, ALU decode -> ALUWB.
- **ALUWB:** result_src=00, reg_write=1 -> FETCH.
- **JAL:** alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 -> ALUWB.
- **BRANCH:** alu_src_a=10, alu_src_b=00, sub, result_src=00 -> FETCH.
  - pc_write = zero for funct3=000.
  - pc_write = !zero for funct3=001 when EN_BNE=1.
  - Other funct3: pc_write=0 and illegal <= 1.
- **ALU decode** (EXECR/EXECI only):
  - funct3 000: sub iff R-type and funct7b5=1, else add.
  - funct3 010: slt. 110: or. 111: and.
  - Other funct3: add and illegal <= 1.
- **Latency with mem_ready always 1:**
  - lw: 5 cycles.
  - sw, R, I, jal: 4 cycles.
  - branch: 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWR adds one cycle.
- **illegal:** cleared only by reset. It does not stall the FSM.

Decomposition:
- **Package ctrl_pkg:**
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, JAL, BRANCH.
  - Opcode localparams: OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR.
  - ALU control codes, imm_src codes, and mux-select codes for result_src, alu_src_a and alu_src_b.
- **Sub-module alu_dec:** combinational funct3/funct7b5/op/alu_op -> alu_control, plus a bad_funct flag.

Test Plan:
- **Reset + lw:** rst_n=0 for 2 cycles, then op=0000011 with mem_ready=1. Expect states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 only in cycle 5 with result_src=01; exactly one ir_write pulse.
- **sw with wait:** op=0100011, mem_ready low 2 cycles in MEMWR. Expect mem_write=1 for 3 consecutive cycles, adr_src=1, imm_src=01, then FETCH.
- **R-type sub vs add:** op=0110011, funct3=000. funct7b5=1 gives alu_control=001 in EXECR; funct7b5=0 gives 000. reg_write in cycle 4.
- **Branches:**
  - beq with zero=1: pc_write=1 in cycle 3.
  - bne (EN_BNE=1) with zero=1: pc_write=0.
  - bne with EN_BNE=0: illegal=1, pc_write=0.
- **Fetch stall + illegal opcode:**
  - mem_ready=0 for 3 cycles in FETCH: pc_write=ir_write=0 throughout, a single pulse when mem_ready rises.
  - op=1111111: illegal sets and stays 1 until reset.
- **Reset mid-instruction:** assert rst_n=0 while in MEMREAD. Next cycle is FETCH with reg_write=0 and illegal=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Purpose : shared types and encodings for the multicycle RV32I control unit.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_t FSM encoding, opcode constants, ALU / imm / mux select codes, imm_sel().
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, JAL, BRANCH
  } state_t;

  // Opcodes seen by the decoder
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // Request from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // alu_control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // imm_src codes
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // result_src codes
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // alu_src_a codes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // alu_src_b codes
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose : bundle between the control unit and the multicycle datapath.
// Latency : n/a (wiring only).
// Backpr. : mem_ready is the only back-pressure; the controller holds its state while it is low.
// Ports   : master = controller (drives strobes/selects), slave = datapath (drives op/funct/zero/mem_ready).
interface multicycle_ctrl_if #(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_SRC_W  = 2
);
  // datapath -> controller
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic                  funct7b5;
  logic                  zero;
  logic                  mem_ready;
  // controller -> datapath
  logic                  pc_write;
  logic                  adr_src;
  logic                  mem_write;
  logic                  ir_write;
  logic [1:0]            result_src;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [IMM_SRC_W-1:0]  imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  reg_write;
  logic                  illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// Purpose : ALU operation decoder; maps FSM request + funct fields to alu_control.
// Latency : combinational.
// Backpr. : none.
// Ports   : op/funct3/funct7b5 from IR, alu_op from FSM -> alu_control, bad_funct (unsupported funct3).
module alu_dec
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  alu_op_t               alu_op,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  bad_funct
);

  logic [2:0] code;

  always_comb begin
    code      = ALU_ADD;
    bad_funct = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 selects sub only for R-type; for addi it is immediate bit 10.
          3'b000:  code = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  code = ALU_SLT;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: begin
            code      = ALU_ADD;
            bad_funct = 1'b1;
          end
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : multicycle RV32I control FSM (fetch/decode/execute/mem/writeback) with ALU decode.
// Latency : lw 5 cycles; sw/R/I/jal 4; branch 3; +1 per mem_ready=0 cycle in FETCH/MEMREAD/MEMWR.
// Backpr. : FETCH, MEMREAD and MEMWR hold until mem_ready (ignored when MEM_WAIT=0).
// Ports   : clk, rst_n (sync, active-low), bus = multicycle_ctrl_if master side.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_SRC_W  = 2,
  parameter int MEM_WAIT   = 1,
  parameter int EN_BNE     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  state_t                state, state_nxt;
  logic                  illegal_q;
  logic                  illegal_set;
  logic                  rdy;
  alu_op_t               alu_op;
  logic                  bad_funct;
  logic [ALU_CTRL_W-1:0] alu_control;

  logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;

  assign rdy = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

  alu_dec #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .op          (bus.op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .alu_op      (alu_op),
    .alu_control (alu_control),
    .bad_funct   (bad_funct)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_write_c   = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RD2;
    alu_op       = ALUOP_ADD;
    illegal_set  = 1'b0;
    case (state)
      FETCH: begin
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURESULT;
        ir_write_c   = rdy;
        pc_write_c   = rdy;
        if (rdy) state_nxt = DECODE;
      end
      DECODE: begin
        // Branch target computed speculatively into ALUOut.
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECR;
          OP_I:         state_nxt = EXECI;
          OP_JAL:       state_nxt = JAL;
          OP_BR:        state_nxt = BRANCH;
          default: begin
            state_nxt   = FETCH;
            illegal_set = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        state_nxt   = (bus.op == OP_SW) ? MEMWR : MEMREAD;
      end
      MEMREAD: begin
        adr_src_c = 1'b1;
        if (rdy) state_nxt = MEMWB;
      end
      MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        state_nxt    = FETCH;
      end
      MEMWR: begin
        // Write held until the memory acknowledges it.
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (rdy) state_nxt = FETCH;
      end
      EXECR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_RD2;
        alu_op      = ALUOP_FUNCT;
        illegal_set = bad_funct;
        state_nxt   = ALUWB;
      end
      EXECI: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        illegal_set = bad_funct;
        state_nxt   = ALUWB;
      end
      ALUWB: begin
        reg_write_c = 1'b1;
        state_nxt   = FETCH;
      end
      JAL: begin
        // PC <- target already in ALUOut; ALU forms OldPC+4 for the link write.
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_write_c  = 1'b1;
        state_nxt   = ALUWB;
      end
      BRANCH: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_RD2;
        alu_op      = ALUOP_SUB;
        state_nxt   = FETCH;
        if (bus.funct3 == 3'b000)
          pc_write_c = bus.zero;
        else if (bus.funct3 == 3'b001 && EN_BNE != 0)
          pc_write_c = !bus.zero;
        else
          illegal_set = 1'b1;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Architectural strobes are gated by reset so nothing commits while it is held.
  assign bus.pc_write    = pc_write_c  & rst_n;
  assign bus.ir_write    = ir_write_c  & rst_n;
  assign bus.mem_write   = mem_write_c & rst_n;
  assign bus.reg_write   = reg_write_c & rst_n;
  assign bus.adr_src     = adr_src_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_control = alu_control;
  assign bus.imm_src     = IMM_SRC_W'(imm_sel(bus.op));
  assign bus.illegal     = illegal_q;

endmodule
